// File: rtl/cdb_broadcaster.sv
// cdb_broadcaster
//   Common Data Bus transmitter. Each functional unit pushes completed
//   results (tag + data) into its own small FIFO; a round-robin arbiter
//   pops one head entry per cycle and drives it as a registered broadcast.
//
// Ports
//   clk, rst      : clock, asynchronous active-high reset
//   flush         : synchronous; drops every queued result and the next broadcast
//   src_valid     : per-source result offer
//   src_rs_num    : per-source 8-bit tag, source i in [8i+7:8i]; tag 0 is dropped
//   src_data      : per-source 32-bit result, source i in [32i+31:32i]
//   src_ready     : per-source "FIFO not full", from registered occupancy only
//   cdb_rs_num    : broadcast tag, 0 when idle
//   cdb_data      : broadcast value, 0 when idle
//   cdb_src       : winning source index, 0 when idle
module cdb_broadcaster #(
    parameter int N_FU  = 4,
    parameter int DEPTH = 2,
    localparam int SW   = (N_FU > 1) ? $clog2(N_FU) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic [N_FU-1:0]      src_valid,
    input  logic [8*N_FU-1:0]    src_rs_num,
    input  logic [32*N_FU-1:0]   src_data,
    output logic [N_FU-1:0]      src_ready,
    output logic [7:0]           cdb_rs_num,
    output logic [31:0]          cdb_data,
    output logic [SW-1:0]        cdb_src
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [7:0]    tag_mem  [N_FU][DEPTH];
    logic [31:0]   data_mem [N_FU][DEPTH];
    logic [PW-1:0] wr_ptr   [N_FU];
    logic [PW-1:0] rd_ptr   [N_FU];
    logic [CW-1:0] count    [N_FU];
    logic [SW-1:0] rr_ptr;

    logic [N_FU-1:0] nonempty;
    logic [N_FU-1:0] push;
    logic [N_FU-1:0] pop;
    logic            found;
    logic [SW-1:0]   winner;
    logic [SW-1:0]   cand;
    logic [SW-1:0]   next_rr;
    int unsigned     idx;
    logic [7:0]      head_tag;
    logic [31:0]     head_data;

    // Ready depends only on registered occupancy, so a full FIFO refuses a
    // push even when it is popped on the same edge.
    always_comb begin
        src_ready = '0;
        nonempty  = '0;
        push      = '0;
        for (int unsigned i = 0; i < N_FU; i++) begin
            src_ready[i] = (count[i] != CW'(DEPTH));
            nonempty[i]  = (count[i] != '0);
            push[i]      = src_valid[i] && src_ready[i] &&
                           (src_rs_num[8*i +: 8] != 8'h00) && !flush;
        end
    end

    // Round-robin search starting at rr_ptr; first non-empty source wins.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        cand   = '0;
        for (int unsigned k = 0; k < N_FU; k++) begin
            idx  = (32'(rr_ptr) + k) % N_FU;
            cand = SW'(idx);
            if (!found && nonempty[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_comb begin
        pop = '0;
        for (int unsigned i = 0; i < N_FU; i++) begin
            pop[i] = found && (winner == SW'(i)) && !flush;
        end
        head_tag  = tag_mem[winner][rd_ptr[winner]];
        head_data = data_mem[winner][rd_ptr[winner]];
        next_rr   = (winner == SW'(N_FU - 1)) ? '0 : winner + SW'(1);
    end

    // Storage is not reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < N_FU; i++) begin
            if (push[i]) begin
                tag_mem[i][wr_ptr[i]]  <= src_rs_num[8*i +: 8];
                data_mem[i][wr_ptr[i]] <= src_data[32*i +: 32];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < N_FU; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
            rr_ptr     <= '0;
            cdb_rs_num <= '0;
            cdb_data   <= '0;
            cdb_src    <= '0;
        end else if (flush) begin
            // rr_ptr deliberately survives a flush.
            for (int unsigned i = 0; i < N_FU; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
            cdb_rs_num <= '0;
            cdb_data   <= '0;
            cdb_src    <= '0;
        end else begin
            for (int unsigned i = 0; i < N_FU; i++) begin
                if (push[i]) begin
                    wr_ptr[i] <= wr_ptr[i] + PW'(1);
                end
                if (pop[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + PW'(1);
                end
                if (push[i] && !pop[i]) begin
                    count[i] <= count[i] + CW'(1);
                end else if (!push[i] && pop[i]) begin
                    count[i] <= count[i] - CW'(1);
                end
            end
            if (found) begin
                cdb_rs_num <= head_tag;
                cdb_data   <= head_data;
                cdb_src    <= winner;
                rr_ptr     <= next_rr;
            end else begin
                cdb_rs_num <= '0;
                cdb_data   <= '0;
                cdb_src    <= '0;
            end
        end
    end

endmodule

// File: tb/tb_cdb_broadcaster.sv
// tb_cdb_broadcaster
//   Directed self-checking bench for cdb_broadcaster (N_FU=4, DEPTH=2).
//   Expected broadcast sequences are hand-computed constants.
module tb_cdb_broadcaster;

    logic         clk;
    logic         rst;
    logic         flush;
    logic [3:0]   src_valid;
    logic [31:0]  src_rs_num;
    logic [127:0] src_data;
    logic [3:0]   src_ready;
    logic [7:0]   cdb_rs_num;
    logic [31:0]  cdb_data;
    logic [1:0]   cdb_src;

    int tests = 0;
    int fails = 0;

    cdb_broadcaster #(.N_FU(4), .DEPTH(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .src_valid  (src_valid),
        .src_rs_num (src_rs_num),
        .src_data   (src_data),
        .src_ready  (src_ready),
        .cdb_rs_num (cdb_rs_num),
        .cdb_data   (cdb_data),
        .cdb_src    (cdb_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] dat(input logic [7:0] t);
        return {16'hC0DE, t, ~t};
    endfunction

    task automatic expect_bc(input string tag, input logic [7:0] rs,
                             input logic [31:0] d, input logic [1:0] s);
        check({tag, "_rs"},   64'(cdb_rs_num), 64'(rs));
        check({tag, "_data"}, 64'(cdb_data),   64'(d));
        check({tag, "_src"},  64'(cdb_src),    64'(s));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int i, input logic [7:0] t, input logic [31:0] d);
        src_valid[i]         = 1'b1;
        src_rs_num[8*i +: 8] = t;
        src_data[32*i +: 32] = d;
    endtask

    task automatic clear_src();
        src_valid  = '0;
        src_rs_num = '0;
        src_data   = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    logic [7:0] rr_tags [4];
    logic [7:0] bp_rs   [9];
    logic [1:0] bp_src  [9];

    initial begin
        rr_tags = '{8'h01, 8'h22, 8'h43, 8'h64};
        bp_rs   = '{8'h21, 8'h41, 8'h61, 8'h02, 8'h22, 8'h42, 8'h62, 8'h63, 8'h00};
        bp_src  = '{2'd1,  2'd2,  2'd3,  2'd0,  2'd1,  2'd2,  2'd3,  2'd3,  2'd0};

        rst   = 1'b1;
        flush = 1'b0;
        clear_src();
        #2;
        expect_bc("reset", 8'h00, 32'h0, 2'd0);
        check("reset_ready", 64'(src_ready), 64'hF);
        tick();
        tick();
        rst = 1'b0;

        // Single result from source 1
        set_src(1, 8'h21, 32'hDEADBEEF);
        tick();
        clear_src();
        check("single_ready", 64'(src_ready), 64'hF);
        expect_bc("single_nobypass", 8'h00, 32'h0, 2'd0);
        tick();
        expect_bc("single_bc", 8'h21, 32'hDEADBEEF, 2'd1);
        tick();
        expect_bc("single_idle", 8'h00, 32'h0, 2'd0);

        // Round-robin fairness from rr_ptr = 0
        do_reset();
        for (int i = 0; i < 4; i++) set_src(i, rr_tags[i], dat(rr_tags[i]));
        tick();
        clear_src();
        expect_bc("rr_push", 8'h00, 32'h0, 2'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            expect_bc($sformatf("rr%0d", i), rr_tags[i], dat(rr_tags[i]), 2'(i));
        end
        set_src(0, 8'h01, dat(8'h01));
        set_src(2, 8'h43, dat(8'h43));
        tick();
        clear_src();
        expect_bc("rr2_push", 8'h00, 32'h0, 2'd0);
        tick();
        expect_bc("rr2_first", 8'h01, dat(8'h01), 2'd0);
        tick();
        expect_bc("rr2_second", 8'h43, dat(8'h43), 2'd2);
        tick();
        expect_bc("rr2_idle", 8'h00, 32'h0, 2'd0);

        // Back-pressure on source 3
        do_reset();
        set_src(0, 8'h01, dat(8'h01));
        set_src(1, 8'h21, dat(8'h21));
        set_src(2, 8'h41, dat(8'h41));
        set_src(3, 8'h61, dat(8'h61));
        tick();
        expect_bc("bp_fill", 8'h00, 32'h0, 2'd0);
        set_src(0, 8'h02, dat(8'h02));
        set_src(1, 8'h22, dat(8'h22));
        set_src(2, 8'h42, dat(8'h42));
        set_src(3, 8'h62, dat(8'h62));
        tick();
        clear_src();
        check("bp_ready_full", 64'(src_ready), 64'h1);
        expect_bc("bp_first", 8'h01, dat(8'h01), 2'd0);
        set_src(3, 8'h63, dat(8'h63));
        for (int k = 0; k < 9; k++) begin
            tick();
            expect_bc($sformatf("bp%0d", k), bp_rs[k],
                      (bp_rs[k] == 8'h00) ? 32'h0 : dat(bp_rs[k]), bp_src[k]);
            if (k < 2) check($sformatf("bp_held%0d", k), 64'(src_ready[3]), 64'h0);
            if (k == 2) check("bp_ready_after_grant", 64'(src_ready[3]), 64'h1);
            if (k == 3) begin
                check("bp_third_accepted", 64'(src_ready[3]), 64'h0);
                clear_src();
            end
        end
        check("bp_ready_end", 64'(src_ready), 64'hF);

        // Tag-0 offer is dropped
        set_src(2, 8'h00, 32'h1234);
        tick();
        clear_src();
        check("tag0_ready", 64'(src_ready), 64'hF);
        expect_bc("tag0_out", 8'h00, 32'h0, 2'd0);
        tick();
        expect_bc("tag0_idle", 8'h00, 32'h0, 2'd0);
        check("tag0_ready2", 64'(src_ready), 64'hF);

        // Flush discards queued results and the concurrent push
        set_src(1, 8'h23, dat(8'h23));
        set_src(2, 8'h44, dat(8'h44));
        set_src(3, 8'h65, dat(8'h65));
        tick();
        clear_src();
        expect_bc("flush_fill", 8'h00, 32'h0, 2'd0);
        flush = 1'b1;
        set_src(0, 8'h05, dat(8'h05));
        tick();
        flush = 1'b0;
        clear_src();
        expect_bc("flush_out", 8'h00, 32'h0, 2'd0);
        check("flush_ready", 64'(src_ready), 64'hF);
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("flush_quiet%0d", k), 64'(cdb_rs_num), 64'h0);
        end

        // Asynchronous reset in the middle of a broadcast
        for (int i = 0; i < 4; i++) set_src(i, rr_tags[i], dat(rr_tags[i]));
        tick();
        clear_src();
        tick();
        tick();
        tick();
        expect_bc("arst_pre", 8'h43, dat(8'h43), 2'd2);
        #2;
        rst = 1'b1;
        #1;
        expect_bc("arst_now", 8'h00, 32'h0, 2'd0);
        check("arst_ready", 64'(src_ready), 64'hF);
        #1;
        rst = 1'b0;
        set_src(1, 8'h26, dat(8'h26));
        set_src(3, 8'h67, dat(8'h67));
        tick();
        clear_src();
        expect_bc("arst_push", 8'h00, 32'h0, 2'd0);
        tick();
        expect_bc("arst_first", 8'h26, dat(8'h26), 2'd1);
        tick();
        expect_bc("arst_second", 8'h67, dat(8'h67), 2'd3);
        tick();
        expect_bc("arst_idle", 8'h00, 32'h0, 2'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
